// File: rtl/saes_encrypt_ctrl.sv
// ----------------------------------------------------------------------------
// saes_encrypt_ctrl
//
// Iterative S-AES encryption engine. One 16-bit block is taken through
// AddRoundKey(K0), round 1 (NibSub, ShiftRows, MixColumns, AddRoundKey(K1))
// and round 2 (NibSub, ShiftRows, AddRoundKey(K2)), one round per clock.
// Round keys are expanded on the fly from the previous round key, so a
// single key-schedule step and a single substitution/ShiftRows datapath
// serve both rounds. MixColumns is used in round 1 and bypassed in round 2.
//
// Ports
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   in_valid    plaintext/key pair available
//   in_ready    engine idle, able to accept a pair
//   plaintext   block to encrypt, nibbles s00,s10,s01,s11 from MSB down
//   key         cipher key, w0 = key[15:8], w1 = key[7:0]
//   out_valid   ciphertext valid, held until out_ready
//   out_ready   downstream accepts the ciphertext
//   ciphertext  registered result
//
// State layout: byte [15:8] is column 0 (s00,s10), byte [7:0] is column 1
// (s01,s11).
// ----------------------------------------------------------------------------

// GF(2^4) MixColumns with matrix [1 4; 4 1], modulus x^4 + x + 1.
module saes_mix_columns (
    input  logic [15:0] din,
    output logic [15:0] dout
);

    // Multiply by x, reducing x^4 to x + 1.
    function automatic logic [3:0] xtime(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'b0011 : 4'b0000);
    endfunction

    function automatic logic [3:0] mul4(input logic [3:0] a);
        return xtime(xtime(a));
    endfunction

    always_comb begin
        dout[15:12] = din[15:12]       ^ mul4(din[11:8]);
        dout[11:8]  = mul4(din[15:12]) ^ din[11:8];
        dout[7:4]   = din[7:4]         ^ mul4(din[3:0]);
        dout[3:0]   = mul4(din[7:4])   ^ din[3:0];
    end

endmodule

module saes_encrypt_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] plaintext,
    input  logic [15:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] ciphertext
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RND1 = 2'd1,
        RND2 = 2'd2,
        DONE = 2'd3
    } fsm_e;

    localparam logic [7:0] RCON1 = 8'h80;
    localparam logic [7:0] RCON2 = 8'h30;

    fsm_e        fsm_q, fsm_d;
    logic [15:0] state_r, state_d;
    logic [15:0] rkey_r, rkey_d;
    logic        out_valid_r, out_valid_d;

    logic [15:0] sr_out;     // ShiftRows(NibSub(state_r))
    logic [15:0] mix_out;    // MixColumns(sr_out)
    logic [15:0] rkey_next;  // next round key derived from rkey_r
    logic [7:0]  rcon;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    function automatic logic [3:0] sbox(input logic [3:0] n);
        logic [3:0] s;
        case (n)
            4'h0: s = 4'h9;
            4'h1: s = 4'h4;
            4'h2: s = 4'hA;
            4'h3: s = 4'hB;
            4'h4: s = 4'hD;
            4'h5: s = 4'h1;
            4'h6: s = 4'h8;
            4'h7: s = 4'h5;
            4'h8: s = 4'h6;
            4'h9: s = 4'h2;
            4'hA: s = 4'h0;
            4'hB: s = 4'h3;
            4'hC: s = 4'hC;
            4'hD: s = 4'hE;
            4'hE: s = 4'hF;
            default: s = 4'h7;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return {sbox(b[7:4]), sbox(b[3:0])};
    endfunction

    function automatic logic [7:0] rot_nib(input logic [7:0] b);
        return {b[3:0], b[7:4]};
    endfunction

    function automatic logic [15:0] nib_sub(input logic [15:0] s);
        return {sub_byte(s[15:8]), sub_byte(s[7:0])};
    endfunction

    // Row 1 holds s10 ([11:8]) and s11 ([3:0]); rotating it swaps them.
    function automatic logic [15:0] shift_rows(input logic [15:0] s);
        return {s[15:12], s[3:0], s[7:4], s[11:8]};
    endfunction

    // One key-schedule step: {w0,w1} -> {w2,w3}.
    function automatic logic [15:0] key_step(input logic [15:0] k,
                                             input logic [7:0]  rc);
        logic [7:0] wa;
        logic [7:0] wb;
        wa = k[15:8] ^ rc ^ sub_byte(rot_nib(k[7:0]));
        wb = wa ^ k[7:0];
        return {wa, wb};
    endfunction

    // ------------------------------------------------------------------
    // Shared round datapath and key schedule
    // ------------------------------------------------------------------
    // In RND1 rkey_r holds K0 and the step yields K1; in RND2 it holds K1
    // and the step yields K2, so only the round constant changes.
    assign rcon      = (fsm_q == RND1) ? RCON1 : RCON2;
    assign rkey_next = key_step(rkey_r, rcon);
    assign sr_out    = shift_rows(nib_sub(state_r));

    saes_mix_columns u_mix_columns (
        .din  (sr_out),
        .dout (mix_out)
    );

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        fsm_d       = fsm_q;
        state_d     = state_r;
        rkey_d      = rkey_r;
        out_valid_d = out_valid_r;

        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = plaintext ^ key;
                    rkey_d  = key;
                    fsm_d   = RND1;
                end
            end
            RND1: begin
                state_d = mix_out ^ rkey_next;
                rkey_d  = rkey_next;
                fsm_d   = RND2;
            end
            RND2: begin
                state_d     = sr_out ^ rkey_next;
                out_valid_d = 1'b1;
                fsm_d       = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset too, because ciphertext
        // is driven straight from state_r and must read zero after reset.
        if (!rst_n) begin
            fsm_q       <= IDLE;
            state_r     <= '0;
            rkey_r      <= '0;
            out_valid_r <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            fsm_q       <= fsm_d;
            state_r     <= state_d;
            rkey_r      <= rkey_d;
            out_valid_r <= out_valid_d;
        end
    end

    assign in_ready   = (fsm_q == IDLE);
    assign out_valid  = out_valid_r;
    assign ciphertext = state_r;

endmodule

// File: tb/tb_saes_encrypt_ctrl.sv
// ----------------------------------------------------------------------------
// tb_saes_encrypt_ctrl
//
// Self-checking bench for saes_encrypt_ctrl. Expected ciphertexts come from a
// behavioural S-AES model that works on a 2x2 nibble matrix with a generic
// GF(2^4) multiplier and a word-array key schedule.
// ----------------------------------------------------------------------------
module tb_saes_encrypt_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] plaintext;
    logic [15:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] ciphertext;

    int errors = 0;
    int checks = 0;

    localparam logic [15:0] KV_PT  = 16'h6F6B;
    localparam logic [15:0] KV_KEY = 16'hA73B;
    localparam logic [15:0] KV_CT  = 16'h0738;

    localparam logic [3:0] SBOX [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                                         4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};

    saes_encrypt_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 4; i++)
            if (b[i]) p = p ^ (8'(a) << i);
        for (int i = 7; i >= 4; i--)
            if (p[i]) p = p ^ (8'h13 << (i - 4));
        return p[3:0];
    endfunction

    function automatic logic [7:0] model_g(input logic [7:0] w, input logic [7:0] rc);
        logic [7:0] r;
        r = {w[3:0], w[7:4]};
        return rc ^ {SBOX[r[7:4]], SBOX[r[3:0]]};
    endfunction

    function automatic logic [15:0] saes_model(input logic [15:0] pt, input logic [15:0] k);
        logic [7:0]  w [6];
        logic [7:0]  rc [2];
        logic [3:0]  s [2][2];
        logic [3:0]  t [2][2];
        logic [3:0]  m [2][2];
        logic [15:0] blk;
        logic [3:0]  tmp;
        rc[0] = 8'h80; rc[1] = 8'h30;
        m[0][0] = 4'd1; m[0][1] = 4'd4; m[1][0] = 4'd4; m[1][1] = 4'd1;
        w[0] = k[15:8];
        w[1] = k[7:0];
        for (int r = 0; r < 2; r++) begin
            w[2*r+2] = w[2*r] ^ model_g(w[2*r+1], rc[r]);
            w[2*r+3] = w[2*r+2] ^ w[2*r+1];
        end
        blk = pt ^ {w[0], w[1]};
        for (int rnd = 1; rnd <= 2; rnd++) begin
            s[0][0] = blk[15:12]; s[1][0] = blk[11:8];
            s[0][1] = blk[7:4];   s[1][1] = blk[3:0];
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++)
                    s[i][j] = SBOX[s[i][j]];
            tmp = s[1][0]; s[1][0] = s[1][1]; s[1][1] = tmp;
            if (rnd == 1) begin
                for (int i = 0; i < 2; i++)
                    for (int c = 0; c < 2; c++)
                        t[i][c] = gf_mul(m[i][0], s[0][c]) ^ gf_mul(m[i][1], s[1][c]);
                s = t;
            end
            blk = {s[0][0], s[1][0], s[0][1], s[1][1]} ^ {w[2*rnd], w[2*rnd+1]};
        end
        return blk;
    endfunction

    // ------------------------------------------------------------------
    // Checking and stimulus helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction: accept, bounded wait for output, optional stall,
    // then a single handshake.
    task automatic run_block(input string tag, input logic [15:0] pt, input logic [15:0] k,
                             input logic [15:0] exp, input int stall);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        plaintext = pt;
        key       = k;
        out_ready = 1'b0;
        tick();
        in_valid  = 1'b0;
        plaintext = 16'($urandom);
        key       = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_ct"}, 32'(ciphertext), 32'(exp));
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_ct"}, 32'(ciphertext), 32'(exp));
            check({tag, "_hold_busy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_released"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int   n;
        int   last;
        int   outs;
        logic extra;
        logic [15:0] pt;
        logic [15:0] k;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        plaintext = 16'h0000;
        key       = 16'h0000;
        repeat (3) tick();

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ct", 32'(ciphertext), 32'd0);
        rst_n = 1'b1;
        tick();

        // Known vector with internal round values, out_ready held high.
        in_valid  = 1'b1;
        plaintext = KV_PT;
        key       = KV_KEY;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        plaintext = 16'h1234;
        key       = 16'h5678;
        check("kv_state_k0", 32'(dut.state_r), 32'h0000_C850);
        check("kv_busy", 32'(in_ready), 32'd0);
        tick();
        check("kv_state_r1", 32'(dut.state_r), 32'h0000_F085);
        check("kv_k1", 32'(dut.rkey_r), 32'h0000_1C27);
        check("kv_valid_early", 32'(out_valid), 32'd0);
        tick();
        check("kv_valid", 32'(out_valid), 32'd1);
        check("kv_ct", 32'(ciphertext), 32'(KV_CT));
        check("kv_model", 32'(ciphertext), 32'(saes_model(KV_PT, KV_KEY)));
        tick();
        check("kv_done_valid", 32'(out_valid), 32'd0);
        check("kv_done_idle", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Backpressure for five cycles.
        run_block("bp", KV_PT, KV_KEY, KV_CT, 5);

        // in_valid pulses while busy must be ignored.
        in_valid  = 1'b1;
        plaintext = KV_PT;
        key       = KV_KEY;
        tick();
        plaintext = 16'hFFFF;               // RND1: still asserting in_valid
        tick();
        in_valid  = 1'b0;
        tick();                             // DONE
        check("ign_valid", 32'(out_valid), 32'd1);
        in_valid  = 1'b1;
        plaintext = 16'hFFFF;
        tick();
        in_valid  = 1'b0;
        check("ign_ct", 32'(ciphertext), 32'(KV_CT));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ign_released", 32'(out_valid), 32'd0);
        extra = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid || !in_ready) extra = 1'b1;
        end
        check("ign_no_second", 32'(extra), 32'd0);

        // Back-to-back with in_valid held high.
        in_valid  = 1'b1;
        plaintext = KV_PT;
        key       = KV_KEY;
        out_ready = 1'b1;
        last = 0;
        outs = 0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (out_valid) begin
                check("b2b_ct", 32'(ciphertext), 32'(KV_CT));
                if (last > 0) check("b2b_interval", 32'(e - last), 32'd4);
                last = e;
                outs++;
            end
        end
        in_valid = 1'b0;
        check("b2b_count", 32'(outs), 32'd10);
        n = 0;
        while (!(in_ready && !out_valid) && n < 10) begin
            tick();
            n++;
        end
        check("b2b_drained", 32'(in_ready && !out_valid), 32'd1);
        out_ready = 1'b0;

        // Reset asserted during RND2 discards the block.
        in_valid  = 1'b1;
        plaintext = KV_PT;
        key       = KV_KEY;
        tick();
        in_valid  = 1'b0;
        tick();                             // now in RND2
        rst_n = 1'b0;
        tick();
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_ct", 32'(ciphertext), 32'd0);
        check("rst_mid_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        extra = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid) extra = 1'b1;
        end
        check("rst_mid_no_output", 32'(extra), 32'd0);
        run_block("rst_after", KV_PT, KV_KEY, KV_CT, 0);

        // All-zero block.
        run_block("zero", 16'h0000, 16'h0000, saes_model(16'h0000, 16'h0000), 0);

        // Random pairs with random output stalls.
        for (int i = 0; i < 256; i++) begin
            pt = 16'($urandom);
            k  = 16'($urandom);
            run_block("rand", pt, k, saes_model(pt, k), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/saes_encrypt_ctrl.md
# saes_encrypt_ctrl

Iterative S-AES encryption engine: a 4-state FSM that sequences one 16-bit block through AddRoundKey(K0), round 1 and round 2, one round per clock. It expands the round keys on the fly and reuses a single nibble-substitution, ShiftRows and MixColumns datapath. It sits between the block-level valid/ready input interface and the ciphertext output port of the S-AES core. It instantiates the team's GF(2^4) MixColumns unit for round 1 and bypasses it in round 2.

## Interface
- No parameters. Block size is fixed at 16 bits and the round count is fixed at 2 by the S-AES definition.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  plaintext/key pair available.
- in_ready  output  1  block can accept a new pair; high only in IDLE.
- plaintext  input  16  block to encrypt; nibble order [15:12],[11:8],[7:4],[3:0] = s00,s10,s01,s11.
- key  input  16  cipher key; w0 = key[15:8], w1 = key[7:0].
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  downstream accepts ciphertext.
- ciphertext  output  16  registered result.

## Operation
- FSM states: IDLE, RND1, RND2, DONE.
- Register contents: 16-bit state_r, 16-bit rkey_r, out_valid_r.
- IDLE:
  - in_ready = 1.
  - On in_valid: state_r <= plaintext ^ key, rkey_r <= key, go to RND1.
- RND1:
  - Compute K1: w2 = w0 ^ 8'h80 ^ SubNib(RotNib(w1)), w3 = w2 ^ w1.
  - state_r <= MixColumns(ShiftRows(NibSub(state_r))) ^ {w2,w3}.
  - rkey_r <= {w2,w3}; go to RND2.
- RND2:
  - Compute K2 from rkey_r with RCON 8'h30.
  - state_r <= ShiftRows(NibSub(state_r)) ^ K2.
  - out_valid <= 1; go to DONE.
- DONE:
  - Hold ciphertext = state_r and out_valid = 1 until out_ready.
  - On out_ready: out_valid <= 0, go to IDLE.
- S-box for nibble values 0..F: 9,4,A,B,D,1,8,5,6,2,0,3,C,E,F,7.
- RotNib swaps the two nibbles of a byte.
- ShiftRows swaps nibbles [11:8] and [3:0].
- MixColumns uses matrix [1 4; 4 1] over GF(2^4), modulus x^4+x+1.
- All XORs are 16-bit wide; there is no carry arithmetic.
- in_valid while not in IDLE is ignored. plaintext and key are sampled only on the accept edge.
- out_ready while out_valid = 0 has no effect.

## Timing
- Reset values: in_ready = 1 (IDLE), out_valid = 0, ciphertext = 16'h0000, state_r = rkey_r = 0.
- Latency: accept at edge N, out_valid = 1 after edge N+2, i.e. visible in cycle N+3 as 2 rounds plus output.
- Minimum issue interval is 4 cycles: accept, RND1, RND2, DONE with out_ready = 1, then IDLE.
- DONE does not accept new input in the same cycle.
- ciphertext is stable for the whole time out_valid = 1.
- rst_n low in any state wins over every other event:
  - next edge goes to IDLE, out_valid = 0, ciphertext = 0;
  - any in-flight block is discarded and produces no output.
- in_valid held high across DONE→IDLE: the new block is accepted in the first IDLE cycle.

## Test plan
- Known vector, plaintext 16'h6F6B, key 16'hA73B, out_ready = 1.
  - Required: ciphertext 16'h0738 with out_valid rising 3 cycles after accept.
  - Internal checks: state_r after accept 16'hC850, K1 16'h1C27, state_r after RND1 16'hF085, K2 16'h7651.
- Backpressure: same vector with out_ready = 0 for 5 cycles.
  - Required: out_valid and ciphertext 16'h0738 held constant, in_ready = 0 throughout.
  - Single handshake on out_ready; IDLE on the next cycle.
- Input ignored while busy: pulse in_valid with plaintext 16'hFFFF during RND1 and DONE.
  - Required: result still 16'h0738 and no second output.
- Back-to-back: in_valid held high with the vector, out_ready = 1.
  - Required: 16'h0738 produced every 4 cycles; no lost or duplicated blocks.
- Reset mid-operation: assert rst_n = 0 during RND2.
  - Required: next cycle out_valid = 0, ciphertext = 0, in_ready = 1.
  - Required: a subsequent 16'h6F6B/16'hA73B request yields 16'h0738.
- All-zero case: plaintext 16'h0000, key 16'h0000.
  - Required: ciphertext matches the bench's S-AES model.
  - Required: 256 random plaintext/key pairs match the model with random out_ready stalls.
